i2s_tx: RTL and testbench

I2S master transmitter. It is the output-side counterpart of the team's i2s receiver and drives an external I2S DAC/codec. Software or DMA pushes PCM samples into an internal FIFO. The block generates sck and ws from the system clock and serialises samples MSB-first on sdo in standard Philips I2S format (one-sck data delay after each ws edge). Its configuration inputs and FIFO status outputs match the receiver's, so both sit behind the same register wrapper style.

---
 rtl/i2s_tx.sv | 205 ++++++++++++++++++++
 tb/tb_i2s_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S master transmitter: PCM sample FIFO, sck/ws generation from the system
// clock and MSB-first serialisation on sdo in Philips I2S format.
// All sck/ws/sdo updates happen on the clk edge where sck falls, so a receiver
// sees stable data on the following sck rise.
module i2s_tx #(
  parameter int FIFO_AW = 4,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [7:0]         sck_prescaler,
  input  logic [4:0]         sample_size,
  input  logic [1:0]         channels,
  input  logic               fifo_wr,
  input  logic [DW-1:0]      fifo_wdata,
  input  logic [FIFO_AW:0]   fifo_level_threshold,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               fifo_level_below,
  output logic               underflow,
  input  logic               underflow_clr,
  output logic               sck,
  output logic               ws,
  output logic               sdo
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  // FIFO storage and state
  logic [DW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               underflow_q, underflow_d;

  // Serialiser state
  logic [7:0]         presc_q, presc_d;
  logic               sck_q, sck_d, ws_q, ws_d, sdo_q, sdo_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]      shift_q, shift_d, dup_q, dup_d;

  // Decode signals
  logic               empty_s, full_s;
  logic [5:0]         n_s, bit_nxt_s;
  logic [4:0]         pos_s, idx_s;
  logic               fall_s, start_s, right_s;
  logic               need_pop_s, pop_s, uf_set_s, wr_acc_s;
  logic [DW-1:0]      slot_word_s, cur_word_s;
  logic               bit_s;

  assign empty_s = (level_q == {(FIFO_AW + 1){1'b0}});
  assign full_s  = (level_q == DEPTH_L);

  // Decode slot position, pop requirement and the next serial bit
  always_comb begin
    n_s       = (sample_size == 5'd0) ? 6'd32 : {1'b0, sample_size};
    fall_s    = en && sck_q && (presc_q == sck_prescaler);
    bit_nxt_s = bit_cnt_q + 6'd1;
    pos_s     = bit_nxt_s[4:0];
    right_s   = bit_nxt_s[5];
    start_s   = fall_s && (pos_s == 5'd0);
    if (right_s) begin
      need_pop_s = start_s && (channels == 2'b11);
    end else begin
      need_pop_s = start_s && (channels != 2'b10);
    end
    pop_s    = need_pop_s && !empty_s;
    uf_set_s = need_pop_s && empty_s;
    wr_acc_s = fifo_wr && !full_s;
    // Word for a slot that is starting: fresh head, mono replay, or silence
    if (pop_s) begin
      slot_word_s = mem_q[rd_ptr_q];
    end else if (right_s && (channels == 2'b00)) begin
      slot_word_s = dup_q;
    end else begin
      slot_word_s = {DW{1'b0}};
    end
    if (start_s) begin
      cur_word_s = slot_word_s;
    end else begin
      cur_word_s = shift_q;
    end
    idx_s = 5'(n_s - 6'd1 - {1'b0, pos_s});
    if ({1'b0, pos_s} < n_s) begin
      bit_s = cur_word_s[idx_s];
    end else begin
      bit_s = 1'b0;
    end
  end

  // Next-state for clock generation, serialiser, FIFO pointers and flags
  always_comb begin
    presc_d     = presc_q;
    sck_d       = sck_q;
    ws_d        = ws_q;
    sdo_d       = sdo_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    dup_d       = dup_q;
    if (!en) begin
      // Idle: a partially sent word is simply dropped
      presc_d   = 8'd0;
      sck_d     = 1'b0;
      ws_d      = 1'b0;
      sdo_d     = 1'b0;
      bit_cnt_d = 6'd63;
      shift_d   = {DW{1'b0}};
      dup_d     = {DW{1'b0}};
    end else if (presc_q == sck_prescaler) begin
      presc_d = 8'd0;
      sck_d   = ~sck_q;
      if (sck_q) begin
        bit_cnt_d = bit_nxt_s;
        ws_d      = (bit_nxt_s >= 6'd31) && (bit_nxt_s <= 6'd62);
        sdo_d     = bit_s;
        if (start_s) begin
          shift_d = slot_word_s;
          if (!right_s && (channels == 2'b00)) begin
            dup_d = slot_word_s;
          end else begin
            dup_d = dup_q;
          end
        end else begin
          shift_d = shift_q;
        end
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      presc_d = presc_q + 8'd1;
    end

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc_s, pop_s})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
      default: level_d = level_q;
    endcase
    // A new underflow event takes priority over a clear in the same cycle
    if (uf_set_s) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q     <= 8'd0;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      sdo_q       <= 1'b0;
      bit_cnt_q   <= 6'd63;
      shift_q     <= {DW{1'b0}};
      dup_q       <= {DW{1'b0}};
      wr_ptr_q    <= {FIFO_AW{1'b0}};
      rd_ptr_q    <= {FIFO_AW{1'b0}};
      level_q     <= {(FIFO_AW + 1){1'b0}};
      underflow_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sck_q       <= sck_d;
      ws_q        <= ws_d;
      sdo_q       <= sdo_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      dup_q       <= dup_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
    end
  end

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= fifo_wdata;
    end
  end

  assign fifo_full        = full_s;
  assign fifo_empty       = empty_s;
  assign fifo_level       = level_q;
  assign fifo_level_below = (level_q < fifo_level_threshold);
  assign underflow        = underflow_q;
  assign sck              = sck_q;
  assign ws               = ws_q;
  assign sdo              = sdo_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus queues expected {ws,sdo} per sck rise,
// a monitor pops and compares on every sck rise.
module tb_i2s_tx;

  logic       clk = 1'b0;
  logic       rst_n, en, fifo_wr, underflow_clr;
  logic [7:0] sck_prescaler;
  logic [4:0] sample_size;
  logic [1:0] channels;
  logic [31:0] fifo_wdata;
  logic [4:0] fifo_level_threshold;
  logic       fifo_full, fifo_empty, fifo_level_below, underflow;
  logic [4:0] fifo_level;
  logic       sck, ws, sdo;

  logic [1:0] exp_q[$];
  int         lv_q[$];
  int         bl_q[$];
  int         checks = 0;
  int         errors = 0;
  int         mon_idx = 0;
  bit         trk_en = 1'b0;
  int         trk_last = 0;
  logic [1:0] mon_e;
  int         k;

  always #5 clk = ~clk;

  i2s_tx #(.FIFO_AW(4), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sck_prescaler(sck_prescaler),
    .sample_size(sample_size), .channels(channels), .fifo_wr(fifo_wr),
    .fifo_wdata(fifo_wdata), .fifo_level_threshold(fifo_level_threshold),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .fifo_level_below(fifo_level_below), .underflow(underflow),
    .underflow_clr(underflow_clr), .sck(sck), .ws(ws), .sdo(sdo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected stream for nb sck rises of one frame starting at bit_cnt 0
  task automatic push_frame(input logic [31:0] lw, input logic [31:0] rw,
                            input int n, input int nb);
    int p;
    logic [31:0] w;
    logic bv;
    for (int b = 0; b < nb; b++) begin
      p = b % 32;
      w = (b < 32) ? lw : rw;
      if (p < n) bv = w[n-1-p];
      else bv = 1'b0;
      exp_q.push_back({((b >= 31) && (b <= 62)) ? 1'b1 : 1'b0, bv});
    end
  endtask

  // The first sck rise after enable happens while bit_cnt is still 63
  task automatic push_pre();
    exp_q.push_back(2'b00);
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_wdata = w;
    fifo_wr = 1'b1;
    @(posedge clk); #1;
    fifo_wr = 1'b0;
  endtask

  task automatic wait_q(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() > target && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_drain"}, (exp_q.size() <= target) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() > target) exp_q.delete();
  endtask

  task automatic idle_now();
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: compare ws/sdo at each sck rise against the scoreboard
  initial forever begin
    @(posedge sck); #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk($sformatf("ws[%0d]", mon_idx), {31'd0, ws}, {31'd0, mon_e[1]});
      chk($sformatf("sdo[%0d]", mon_idx), {31'd0, sdo}, {31'd0, mon_e[0]});
      mon_idx++;
    end
  end

  // Level tracker: records each change of fifo_level with fifo_level_below
  initial forever begin
    @(posedge clk); #1;
    if (trk_en && (fifo_level != trk_last)) begin
      lv_q.push_back(int'(fifo_level));
      bl_q.push_back(int'(fifo_level_below));
      trk_last = int'(fifo_level);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; fifo_wr = 1'b0; underflow_clr = 1'b0;
    sck_prescaler = 8'd4; sample_size = 5'd18; channels = 2'b10;
    fifo_wdata = 32'd0; fifo_level_threshold = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_sck", {31'd0, sck}, 32'd0);
    chk("rst_ws", {31'd0, ws}, 32'd0);
    chk("rst_sdo", {31'd0, sdo}, 32'd0);
    chk("rst_bitcnt", {26'd0, dut.bit_cnt_q}, 32'd63);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_uf", {31'd0, underflow}, 32'd0);

    // Test 1: clock timing and ws framing, prescaler 4, silent stream
    push_pre();
    push_frame(32'd0, 32'd0, 18, 64);
    push_frame(32'd0, 32'd0, 18, 64);
    en = 1'b1;
    k = 0;
    while (sck !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    chk("t1_first_rise", k, 32'd5);
    while (sck !== 1'b0 && k < 100) begin @(posedge clk); #1; k++; end
    chk("t1_first_fall", k, 32'd10);
    chk("t1_bitcnt0", {26'd0, dut.bit_cnt_q}, 32'd0);
    while (sck !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    chk("t1_period", k - 5, 32'd10);
    wait_q(0, 3000, "t1");
    idle_now();
    chk("t1_uf", {31'd0, underflow}, 32'd0);

    // Test 2: stereo, 18-bit samples
    sck_prescaler = 8'd1; channels = 2'b11; sample_size = 5'd18;
    push_word(32'h0002A5A5);
    push_word(32'h00015A5A);
    chk("t2_level2", {27'd0, fifo_level}, 32'd2);
    lv_q.delete(); bl_q.delete(); trk_last = 2; trk_en = 1'b1;
    push_pre();
    push_frame(32'h0002A5A5, 32'h00015A5A, 18, 64);
    en = 1'b1;
    wait_q(0, 1000, "t2");
    idle_now();
    trk_en = 1'b0;
    chk("t2_nchanges", lv_q.size(), 32'd2);
    if (lv_q.size() == 2) begin
      chk("t2_level1", lv_q[0], 32'd1);
      chk("t2_level0", lv_q[1], 32'd0);
    end
    chk("t2_uf", {31'd0, underflow}, 32'd0);

    // Test 3: left-only, then underflow on the fourth frame
    channels = 2'b01; sample_size = 5'd8;
    push_word(32'h000000A5);
    push_word(32'h0000003C);
    push_word(32'h00000081);
    push_pre();
    push_frame(32'hA5, 32'h0, 8, 64);
    push_frame(32'h3C, 32'h0, 8, 64);
    push_frame(32'h81, 32'h0, 8, 64);
    push_frame(32'h0, 32'h0, 8, 64);
    en = 1'b1;
    wait_q(64, 3000, "t3a");
    chk("t3_empty", {31'd0, fifo_empty}, 32'd1);
    chk("t3_uf_before", {31'd0, underflow}, 32'd0);
    wait_q(0, 1000, "t3b");
    idle_now();
    chk("t3_uf_set", {31'd0, underflow}, 32'd1);
    underflow_clr = 1'b1;
    @(posedge clk); #1;
    underflow_clr = 1'b0;
    chk("t3_uf_clr", {31'd0, underflow}, 32'd0);

    // Test 4: overfill by one, then drain watching the threshold
    channels = 2'b11; sample_size = 5'd8; fifo_level_threshold = 5'd5;
    fifo_wr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      fifo_wdata = 32'hA0 + i;
      @(posedge clk); #1;
      if (i == 15) chk("t4_full16", {31'd0, fifo_full}, 32'd1);
    end
    fifo_wr = 1'b0;
    chk("t4_level16", {27'd0, fifo_level}, 32'd16);
    chk("t4_below_hi", {31'd0, fifo_level_below}, 32'd0);
    lv_q.delete(); bl_q.delete(); trk_last = 16; trk_en = 1'b1;
    push_pre();
    for (int f = 0; f < 8; f++) push_frame(32'hA0 + 2*f, 32'hA1 + 2*f, 8, 64);
    en = 1'b1;
    wait_q(0, 4000, "t4");
    idle_now();
    trk_en = 1'b0;
    chk("t4_nchanges", lv_q.size(), 32'd16);
    if (lv_q.size() == 16) begin
      chk("t4_lvl5", lv_q[10], 32'd5);
      chk("t4_below_at5", bl_q[10], 32'd0);
      chk("t4_lvl4", lv_q[11], 32'd4);
      chk("t4_below_at4", bl_q[11], 32'd1);
    end
    chk("t4_empty", {31'd0, fifo_empty}, 32'd1);
    chk("t4_uf", {31'd0, underflow}, 32'd0);

    // Test 5: mono duplicated, 32-bit samples
    channels = 2'b00; sample_size = 5'd0;
    push_word(32'hDEADBEEF);
    push_word(32'h12345678);
    push_pre();
    push_frame(32'hDEADBEEF, 32'hDEADBEEF, 32, 64);
    push_frame(32'h12345678, 32'h12345678, 32, 64);
    en = 1'b1;
    wait_q(64, 1000, "t5a");
    chk("t5_level1", {27'd0, fifo_level}, 32'd1);
    wait_q(0, 1000, "t5b");
    idle_now();
    chk("t5_level0", {27'd0, fifo_level}, 32'd0);
    chk("t5_uf", {31'd0, underflow}, 32'd0);

    // Test 6: disable mid-right-slot, reset while streaming, re-enable latency
    channels = 2'b11; sample_size = 5'd16;
    push_word(32'h1234);
    push_word(32'h5678);
    push_word(32'h9ABC);
    push_word(32'hDEF0);
    push_pre();
    push_frame(32'h1234, 32'h5678, 16, 48);
    en = 1'b1;
    wait_q(0, 1000, "t6");
    chk("t6_ws_before", {31'd0, ws}, 32'd1);
    idle_now();
    chk("t6_dis_sck", {31'd0, sck}, 32'd0);
    chk("t6_dis_ws", {31'd0, ws}, 32'd0);
    chk("t6_dis_sdo", {31'd0, sdo}, 32'd0);
    chk("t6_dis_bitcnt", {26'd0, dut.bit_cnt_q}, 32'd63);
    chk("t6_dis_level", {27'd0, fifo_level}, 32'd2);
    en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_sck_high", {31'd0, sck}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_sck", {31'd0, sck}, 32'd0);
    chk("t6_rst_ws", {31'd0, ws}, 32'd0);
    chk("t6_rst_sdo", {31'd0, sdo}, 32'd0);
    chk("t6_rst_bitcnt", {26'd0, dut.bit_cnt_q}, 32'd63);
    chk("t6_rst_level", {27'd0, fifo_level}, 32'd0);
    rst_n = 1'b1; en = 1'b0;
    push_word(32'h8001);
    en = 1'b1;
    k = 0;
    while (sdo !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    chk("t6_first_msb", k, 32'd4);
    chk("t6_bitcnt0", {26'd0, dut.bit_cnt_q}, 32'd0);
    idle_now();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
